// File: rtl/div_pkg.sv
// Shared types and constants for the sequential radix-2 restoring divider.
`timescale 1ns/1ps
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor, keep or restore.
`timescale 1ns/1ps
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  // The partial remainder is always below the divisor, so the shifted value is below
  // twice the divisor and a WIDTH+1 bit trial difference carries a valid sign bit.
  assign w_shift = {i_rem, i_bit};
  assign w_trial = w_shift - {1'b0, i_divisor};
  assign o_qbit  = ~w_trial[WIDTH];
  assign o_rem   = o_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative signed/unsigned divider, one quotient bit per clock; result packed {remainder, quotient}.
`timescale 1ns/1ps
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] s,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(WIDTH);

  state_t             r_state;
  state_t             w_nextState;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_div;
  logic               r_negQuo;
  logic               r_negRem;
  logic [2*WIDTH-1:0] r_s;
  logic               r_busy;
  logic               r_done;

  logic               w_load;
  logic               w_step;
  logic               w_finish;
  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic [WIDTH-1:0]   w_stepRem;
  logic               w_qBit;
  logic [WIDTH-1:0]   w_quoFix;
  logic [WIDTH-1:0]   w_remFix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = CALC;
      CALC:    if (r_cnt == '0) w_nextState = FIX;
      FIX:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      IDLE:    w_load   = start;
      CALC:    w_step   = 1'b1;
      FIX:     w_finish = 1'b1;
      default: ;
    endcase
  end

  // Unary minus of the most negative value yields 2^(W-1), which is the correct unsigned magnitude.
  assign w_magA = (is_signed && a[WIDTH-1]) ? -a : a;
  assign w_magB = (is_signed && b[WIDTH-1]) ? -b : b;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_divisor (r_div),
    .i_bit     (r_quo[WIDTH-1]),
    .o_rem     (w_stepRem),
    .o_qbit    (w_qBit)
  );

  // Divide-by-zero forces an all-ones quotient; the remainder already equals the dividend.
  assign w_quoFix = (r_div == '0) ? '1 : (r_negQuo ? -r_quo : r_quo);
  assign w_remFix = r_negRem ? -r_rem : r_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_negQuo <= 1'b0;
      r_negRem <= 1'b0;
      r_s      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if (w_load) begin
        r_div    <= w_magB;
        r_quo    <= w_magA;
        r_rem    <= '0;
        r_cnt    <= CW'(WIDTH - 1);
        r_negQuo <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        r_negRem <= is_signed & a[WIDTH-1];
        r_busy   <= 1'b1;
      end else if (w_step) begin
        r_rem <= w_stepRem;
        r_quo <= {r_quo[WIDTH-2:0], w_qBit};
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_finish) begin
        r_s    <= {w_remFix, w_quoFix};
        r_busy <= 1'b0;
      end
      r_done <= w_finish;
    end
  end

  assign s    = r_s;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic reference model checked every cycle plus literal results.
`timescale 1ns/1ps
module tb_seq_divider;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           start = 1'b0;
  logic           isSigned = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [2*W-1:0] s;
  logic           busy;
  logic           done;

  int errors = 0;
  int checks = 0;

  logic [2*W-1:0] mS = '0;
  logic [2*W-1:0] mRes = '0;
  int             mCnt = 0;
  logic           mDone = 1'b0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (isSigned),
    .a         (a),
    .b         (b),
    .s         (s),
    .busy      (busy),
    .done      (done)
  );

  // Reference result straight from the arithmetic rules, using native signed division.
  function automatic logic [2*W-1:0] refDiv(input logic sgn, input logic [W-1:0] av, input logic [W-1:0] bv);
    int sa;
    int sb;
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (bv == 0) return {av, 32'hFFFFFFFF};
    if (!sgn) return {av % bv, av / bv};
    if (av == 32'h80000000 && bv == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
    sa = av;
    sb = bv;
    q = sa / sb;
    r = sa % sb;
    return {r, q};
  endfunction

  task automatic checkOutput(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle model: an accepted request completes exactly W+1 edges later; requests while busy are dropped.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mCnt  = 0;
        mDone = 1'b0;
        mS    = '0;
      end else begin
        mDone = 1'b0;
        if (mCnt > 0) begin
          mCnt--;
          if (mCnt == 0) begin
            mDone = 1'b1;
            mS    = mRes;
          end
        end else if (start) begin
          mRes = refDiv(isSigned, a, b);
          mCnt = W + 1;
        end
        #1;
        if (rst_n) begin
          checkOutput("cyc_done", {63'd0, done}, {63'd0, mDone});
          checkOutput("cyc_busy", {63'd0, busy}, {63'd0, (mCnt > 0)});
          checkOutput("cyc_s", s, mS);
        end
      end
    end
  end

  task automatic applyStimulus(input logic sgn, input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    isSigned = sgn;
    a        = av;
    b        = bv;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    a        = $urandom;
    b        = $urandom;
    isSigned = 1'($urandom_range(0, 1));
  endtask

  task automatic waitDone(input string name, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk);
      #2;
      if (done) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: done never seen, expected within 40 cycles", name);
    end
  endtask

  task automatic runOp(input string name, input logic sgn, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [2*W-1:0] expS);
    logic ok;
    applyStimulus(sgn, av, bv);
    waitDone(name, ok);
    if (ok) checkOutput(name, s, expS);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic ok;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_s", s, '0);
    checkOutput("reset_busy", {63'd0, busy}, '0);
    checkOutput("reset_done", {63'd0, done}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    runOp("udiv_100_7",   1'b0, 32'd100,        32'd7,          {32'd2, 32'd14});
    runOp("udiv_large",   1'b0, 32'd3000000000, 32'd7,          {32'd4, 32'd428571428});
    runOp("sdiv_m7_2",    1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD});
    runOp("sdiv_7_m2",    1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1, 32'hFFFFFFFD});
    runOp("udiv_by0",     1'b0, 32'd5,          32'd0,          {32'd5, 32'hFFFFFFFF});
    runOp("sdiv_by0",     1'b1, 32'd5,          32'd0,          {32'd5, 32'hFFFFFFFF});
    runOp("sdiv_m5_by0",  1'b1, 32'hFFFFFFFB,   32'd0,          {32'hFFFFFFFB, 32'hFFFFFFFF});
    runOp("sdiv_ovf",     1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0, 32'h80000000});
    runOp("sdiv_min_1",   1'b1, 32'h80000000,   32'd1,          {32'd0, 32'h80000000});
    runOp("sdiv_m100_m7", 1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE, 32'd14});
    runOp("udiv_a_lt_b",  1'b0, 32'd3,          32'd10,         {32'd3, 32'd0});
    runOp("udiv_min_max", 1'b0, 32'h80000000,   32'hFFFFFFFF,   {32'h80000000, 32'd0});
    runOp("udiv_max_max", 1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   {32'd0, 32'd1});

    // A second start in the middle of an operation must be dropped.
    applyStimulus(1'b0, 32'd100, 32'd7);
    repeat (8) @(negedge clk);
    start = 1'b1;
    a     = 32'd50;
    b     = 32'd3;
    @(negedge clk);
    start = 1'b0;
    waitDone("ignore_start", ok);
    if (ok) checkOutput("ignore_start", s, {32'd2, 32'd14});
    repeat (40) @(negedge clk);

    // Asynchronous reset in the middle of an operation.
    applyStimulus(1'b0, 32'd1000, 32'd3);
    repeat (14) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_s", s, '0);
    checkOutput("abort_busy", {63'd0, busy}, '0);
    checkOutput("abort_done", {63'd0, done}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    runOp("after_abort", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333});

    // start held high: the next request is taken in the idle cycle that carries done.
    @(negedge clk);
    isSigned = 1'b0;
    a        = 32'd20;
    b        = 32'd6;
    start    = 1'b1;
    waitDone("b2b_first", ok);
    if (ok) checkOutput("b2b_first", s, {32'd2, 32'd3});
    a = 32'd21;
    waitDone("b2b_second", ok);
    start = 1'b0;
    if (ok) checkOutput("b2b_second", s, {32'd3, 32'd3});

    repeat (40) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
